// File: rtl/shared_counter_pkg.sv
// rtl/shared_counter_pkg.sv - shared types and constants for the time-shared counter scheduler
package shared_counter_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int cmax(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx
);

    logic found;
    int   idx;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                win[idx]   = 1'b1;
                win_idx    = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/shared_counter_sched.sv
// rtl/shared_counter_sched.sv - round-robin scheduler time-sharing one loadable up-counter
module shared_counter_sched
    import shared_counter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_val,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [W-1:0]      cnt_out
);

    localparam int          IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [W-1:0] CMAX = W'(cmax(W));

    state_t          state_q, state_d;
    logic [W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]    val_q, val_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   win_q, win_d;
    logic [IW-1:0]   ptr_q, ptr_d;

    logic [NREQ-1:0] arb_win;
    logic [IW-1:0]   arb_idx;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .win     (arb_win),
        .win_idx (arb_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            val_q   <= '0;
            gnt_q   <= '0;
            win_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            gnt_q   <= gnt_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|req) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_COUNT;
            ST_COUNT: if (cnt_q == CMAX) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: grant latch, captured value, counter and round-robin pointer
    always_comb begin
        cnt_d = cnt_q;
        val_d = val_q;
        gnt_d = gnt_q;
        win_d = win_q;
        ptr_d = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d = arb_win;
                    win_d = arb_idx;
                    val_d = req_val[int'(arb_idx)*W +: W];
                end
            end
            ST_LOAD:  cnt_d = val_q;
            ST_COUNT: if (cnt_q != CMAX) cnt_d = cnt_q + 1'b1;
            ST_DONE: begin
                gnt_d = '0;
                if (int'(win_q) == NREQ - 1) ptr_d = '0;
                else                         ptr_d = win_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        gnt     = gnt_q;
        done    = (state_q == ST_DONE) ? gnt_q : '0;
        busy    = (state_q != ST_IDLE);
        cnt_out = cnt_q;
    end

endmodule
